dmem_port_arbiter: RTL and testbench

//  Shares the single DataMemory handshake port (address/data_in/bytemask/write/start_access -> access_done/data_out)

---
 rtl/dmem_port_arbiter.sv | 219 +++++++++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares the single DataMemory handshake port among NUM_REQ
// requesters (requester 0 is the pipeline MEM stage, the rest are loader/debug).
// Round-robin grant, the winner's command is held in registers until the memory
// reports access_done, and completion plus read data are returned per requester.
// Optional feature macro: DMEM_ARB_STATS_EN adds saturating grant/wait counters.
module dmem_port_arbiter #(
  parameter int DMEM_ADDRESS_WIDTH = 20,
  parameter int NUM_REQ            = 2,
  parameter int STAT_WIDTH         = 16
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic [NUM_REQ-1:0]                            req_valid_i,
  input  logic [NUM_REQ-1:0][DMEM_ADDRESS_WIDTH-1:0]    req_address_i,
  input  logic [NUM_REQ-1:0][63:0]                      req_data_in_i,
  input  logic [NUM_REQ-1:0][7:0]                       req_bytemask_i,
  input  logic [NUM_REQ-1:0]                            req_write_i,
  output logic [NUM_REQ-1:0]                            req_done_o,
  output logic [63:0]                                   req_data_out_o,
  output logic [DMEM_ADDRESS_WIDTH-1:0]                 mem_address_o,
  output logic [63:0]                                   mem_data_in_o,
  output logic [7:0]                                    mem_bytemask_o,
  output logic                                          mem_write_o,
  output logic                                          mem_start_access_o,
  input  logic                                          mem_access_done_i,
  input  logic [63:0]                                   mem_data_out_i
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [NUM_REQ-1:0][STAT_WIDTH-1:0]            stat_grants_o,
  output logic [NUM_REQ-1:0][STAT_WIDTH-1:0]            stat_wait_o
`endif
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Elaboration-time guards on the configuration space this arbiter supports.
  if (NUM_REQ < 2 || NUM_REQ > 4) begin : gBadNumReq
    $error("dmem_port_arbiter: NUM_REQ must be in 2..4");
  end
  if (STAT_WIDTH < 1) begin : gBadStatWidth
    $error("dmem_port_arbiter: STAT_WIDTH must be at least 1");
  end
  if (DMEM_ADDRESS_WIDTH < 4) begin : gBadAddrWidth
    $error("dmem_port_arbiter: DMEM_ADDRESS_WIDTH must be at least 4");
  end

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e                        state_q;
  logic [GW-1:0]                 grantId_q;
  logic [GW-1:0]                 rrPtr_q;
  logic [DMEM_ADDRESS_WIDTH-1:0] memAddress_q;
  logic [63:0]                   memDataIn_q;
  logic [7:0]                    memBytemask_q;
  logic                          memWrite_q;
  logic                          memStart_q;

  logic                          accessDone;
  logic [NUM_REQ-1:0]            ownerMask;
  logic [NUM_REQ-1:0]            eligible;
  logic                          pickValid_d;
  logic [GW-1:0]                 pickId_d;
  logic [GW-1:0]                 rrPtr_d;
  logic                          canGrant;
  logic                          grantNow;

  // Index of the requester that sits 'offset' places after 'base' in ring order.
  function automatic logic [GW-1:0] rotIdx(input logic [GW-1:0] base, input int offset);
    int s;
    s = int'(base) + offset;
    if (s >= NUM_REQ) begin
      s = s - NUM_REQ;
    end
    return GW'(s);
  endfunction

  assign accessDone = (state_q == BUSY) && mem_access_done_i;

  // One-hot view of the current owner; empty while no access is in flight.
  always_comb begin
    ownerMask = '0;
    if (state_q == BUSY) begin
      ownerMask[grantId_q] = 1'b1;
    end
  end

  // The finishing owner still shows valid in its done cycle, so it is masked out
  // there to let another requester take the port back-to-back.
  always_comb begin
    eligible = req_valid_i;
    if (accessDone) begin
      eligible = req_valid_i & ~ownerMask;
    end
  end

  // Round-robin search: first eligible requester at or after the pointer wins.
  always_comb begin
    pickValid_d = 1'b0;
    pickId_d    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (eligible[rotIdx(rrPtr_q, k)]) begin
        pickValid_d = 1'b1;
        pickId_d    = rotIdx(rrPtr_q, k);
      end
    end
  end

  // Pointer moves just past the winner so it becomes lowest priority next time.
  always_comb begin
    rrPtr_d = pickId_d + GW'(1);
    if (pickId_d == GW'(NUM_REQ - 1)) begin
      rrPtr_d = '0;
    end
  end

  assign canGrant = (state_q == IDLE) || accessDone;
  assign grantNow = canGrant && pickValid_d;

  // Arbiter FSM: owns the grant, the ring pointer and the registered memory command.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      memStart_q    <= 1'b0;
      memAddress_q  <= '0;
      memDataIn_q   <= '0;
      memBytemask_q <= '0;
      memWrite_q    <= 1'b0;
      grantId_q     <= '0;
      rrPtr_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pickValid_d) begin
            state_q    <= BUSY;
            memStart_q <= 1'b1;
          end
        end
        BUSY: begin
          if (accessDone && !pickValid_d) begin
            state_q    <= IDLE;
            memStart_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= IDLE;
          memStart_q <= 1'b0;
        end
      endcase
      if (grantNow) begin
        memAddress_q  <= req_address_i[pickId_d];
        memDataIn_q   <= req_data_in_i[pickId_d];
        memBytemask_q <= req_bytemask_i[pickId_d];
        memWrite_q    <= req_write_i[pickId_d];
        grantId_q     <= pickId_d;
        rrPtr_q       <= rrPtr_d;
      end
    end
  end

  assign mem_address_o      = memAddress_q;
  assign mem_data_in_o      = memDataIn_q;
  assign mem_bytemask_o     = memBytemask_q;
  assign mem_write_o        = memWrite_q;
  assign mem_start_access_o = memStart_q;

  // Completion goes straight back to the owner in the same cycle memory reports it;
  // an access cut short by reset never reports completion.
  always_comb begin
    req_done_o = '0;
    if (accessDone && !reset) begin
      req_done_o[grantId_q] = 1'b1;
    end
  end

  assign req_data_out_o = mem_data_out_i;

`ifdef DMEM_ARB_STATS_EN
  logic [NUM_REQ-1:0][STAT_WIDTH-1:0] statGrants_q;
  logic [NUM_REQ-1:0][STAT_WIDTH-1:0] statWait_q;

  // Saturating per-requester counters: grants won and cycles spent waiting.
  always_ff @(posedge clk) begin
    if (reset) begin
      statGrants_q <= '0;
      statWait_q   <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grantNow && (pickId_d == GW'(i)) && (statGrants_q[i] != '1)) begin
          statGrants_q[i] <= statGrants_q[i] + STAT_WIDTH'(1);
        end
        if (req_valid_i[i] && !ownerMask[i] && (statWait_q[i] != '1)) begin
          statWait_q[i] <= statWait_q[i] + STAT_WIDTH'(1);
        end
      end
    end
  end

  assign stat_grants_o = statGrants_q;
  assign stat_wait_o   = statWait_q;
`else
`endif

`ifndef SYNTHESIS
  // The owner must keep asking until its completion; dropping early is a requester bug.
  ownerKeepsValid : assert property (@(posedge clk) disable iff (reset)
    (state_q == BUSY) |-> req_valid_i[grantId_q]);

  // DataMemory works on 64-bit words, so a granted address must be 8-byte aligned.
  alignedAtGrant : assert property (@(posedge clk) disable iff (reset)
    grantNow |-> (req_address_i[pickId_d][2:0] == 3'b000));

  // Only one requester can own the port, so at most one completion per cycle.
  singleDone : assert property (@(posedge clk) $onehot0(req_done_o));
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed scenarios against dmem_port_arbiter with a
// 3-cycle DataMemory stub, a rule-level arbitration model and per-cycle compare.
// Build with DMEM_ARB_STATS_EN defined to also cover the statistics counters.
module tb_dmem_port_arbiter;

  localparam int AW = 20;
  localparam int NR = 2;
  localparam int SW = 3;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [63:0]   data;
    logic [7:0]    mask;
    logic          write;
  } cmd_t;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [NR-1:0]          req_valid;
  logic [NR-1:0][AW-1:0]  req_address;
  logic [NR-1:0][63:0]    req_data_in;
  logic [NR-1:0][7:0]     req_bytemask;
  logic [NR-1:0]          req_write;
  logic [NR-1:0]          req_done;
  logic [63:0]            req_data_out;
  logic [AW-1:0]          mem_address;
  logic [63:0]            mem_data_in;
  logic [7:0]             mem_bytemask;
  logic                   mem_write;
  logic                   mem_start_access;
  logic                   mem_access_done;
  logic [63:0]            mem_data_out;
`ifdef DMEM_ARB_STATS_EN
  logic [NR-1:0][SW-1:0]  stat_grants;
  logic [NR-1:0][SW-1:0]  stat_wait;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_port_arbiter #(
    .DMEM_ADDRESS_WIDTH(AW),
    .NUM_REQ(NR),
    .STAT_WIDTH(SW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid_i(req_valid),
    .req_address_i(req_address),
    .req_data_in_i(req_data_in),
    .req_bytemask_i(req_bytemask),
    .req_write_i(req_write),
    .req_done_o(req_done),
    .req_data_out_o(req_data_out),
    .mem_address_o(mem_address),
    .mem_data_in_o(mem_data_in),
    .mem_bytemask_o(mem_bytemask),
    .mem_write_o(mem_write),
    .mem_start_access_o(mem_start_access),
    .mem_access_done_i(mem_access_done),
    .mem_data_out_i(mem_data_out)
`ifdef DMEM_ARB_STATS_EN
    ,
    .stat_grants_o(stat_grants),
    .stat_wait_o(stat_wait)
`endif
  );

  function automatic logic [63:0] initWord(input int i);
    return {32'h1111_0000 + 32'(i), 32'h2222_0000 + 32'(i)};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  // DataMemory stub: completion on the third cycle of each access, byte-masked writes.
  logic [63:0] stubMem [0:31];
  logic [1:0]  stubCnt;
  wire         stubDone = mem_start_access && (stubCnt == 2'd2);
  assign mem_access_done = stubDone;
  assign mem_data_out    = stubMem[mem_address[7:3]];

  // Stub sequencing and write commit; memory image is restored by reset.
  always @(posedge clk) begin
    if (reset) begin
      stubCnt <= 2'd0;
      for (int i = 0; i < 32; i++) stubMem[i] <= initWord(i);
    end else if (mem_start_access) begin
      if (stubDone) begin
        stubCnt <= 2'd0;
        if (mem_write) begin
          for (int b = 0; b < 8; b++) begin
            if (mem_bytemask[b]) stubMem[mem_address[7:3]][8*b +: 8] <= mem_data_in[8*b +: 8];
          end
        end
      end else begin
        stubCnt <= stubCnt + 2'd1;
      end
    end else begin
      stubCnt <= 2'd0;
    end
  end

  // Rule-level model: who owns the port, which command it holds, memory contents, stats.
  logic        mBusy;
  int          mOwner;
  int          mLast;
  cmd_t        mCmd;
  logic [63:0] shadow [0:31];
  int          grantLog[$];
  logic [SW-1:0] mGrants [NR];
  logic [SW-1:0] mWait [NR];

  // Model update on each clock: complete, hand off by round robin, count stats.
  always @(posedge clk) begin
    bit finishing;
    int pick;
    int c;
    if (reset) begin
      mBusy  <= 1'b0;
      mOwner <= 0;
      mLast  <= NR - 1;
      mCmd   <= '0;
      for (int i = 0; i < 32; i++) shadow[i] <= initWord(i);
      for (int i = 0; i < NR; i++) begin
        mGrants[i] <= '0;
        mWait[i]   <= '0;
      end
    end else begin
      finishing = mBusy && stubDone;
      pick = -1;
      for (int i = 0; i < NR; i++) begin
        if (req_valid[i] && !(mBusy && mOwner == i) && mWait[i] != '1) mWait[i] <= mWait[i] + 1'b1;
      end
      if (finishing && mCmd.write) begin
        for (int b = 0; b < 8; b++) begin
          if (mCmd.mask[b]) shadow[mCmd.addr[7:3]][8*b +: 8] <= mCmd.data[8*b +: 8];
        end
      end
      if (!mBusy || finishing) begin
        for (int k = 1; k <= NR; k++) begin
          c = (mLast + k) % NR;
          if (pick < 0 && req_valid[c] && !(finishing && c == mOwner)) pick = c;
        end
        if (pick >= 0) begin
          mBusy  <= 1'b1;
          mOwner <= pick;
          mLast  <= pick;
          mCmd   <= {req_address[pick], req_data_in[pick], req_bytemask[pick], req_write[pick]};
          grantLog.push_back(pick);
          if (mGrants[pick] != '1) mGrants[pick] <= mGrants[pick] + 1'b1;
        end else begin
          mBusy <= 1'b0;
        end
      end
    end
  end

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    logic [NR-1:0] expDone;
    expDone = '0;
    if (mBusy && stubDone && !reset) expDone[mOwner] = 1'b1;
    checkOutput("memStart", mem_start_access, mBusy);
    checkOutput("memAddress", mem_address, mCmd.addr);
    checkOutput("memDataIn", mem_data_in, mCmd.data);
    checkOutput("memBytemask", mem_bytemask, mCmd.mask);
    checkOutput("memWrite", mem_write, mCmd.write);
    checkOutput("reqDone", req_done, expDone);
    if (expDone != '0 && !mCmd.write) checkOutput("reqDataOut", req_data_out, shadow[mCmd.addr[7:3]]);
`ifdef DMEM_ARB_STATS_EN
    for (int i = 0; i < NR; i++) begin
      checkOutput("statGrants", stat_grants[i], mGrants[i]);
      checkOutput("statWait", stat_wait[i], mWait[i]);
    end
`endif
  end

  // Observation helpers for the scenario-level literal checks.
  int          cycleNo = 0;
  int          firstHigh;
  int          lastHigh;
  int          highCount;
  int          doneCount;
  logic [63:0] doneData [NR];
  logic [NR-1:0] doneSample;

  // Track start-access span and captured completion data each cycle.
  always @(negedge clk) begin
    cycleNo++;
    doneSample <= req_done;
    if (mem_start_access) begin
      if (firstHigh < 0) firstHigh = cycleNo;
      lastHigh = cycleNo;
      highCount++;
    end
    for (int i = 0; i < NR; i++) begin
      if (req_done[i]) begin
        doneData[i] = req_data_out;
        doneCount++;
      end
    end
  end

  cmd_t reqQ0[$];
  cmd_t reqQ1[$];

  // Requester behaviour: hold the head command until its done, then present the next.
  initial begin
    req_valid    = '0;
    req_address  = '0;
    req_data_in  = '0;
    req_bytemask = '0;
    req_write    = '0;
    forever begin
      @(posedge clk);
      #1;
      if (doneSample[0] && reqQ0.size() > 0) void'(reqQ0.pop_front());
      if (doneSample[1] && reqQ1.size() > 0) void'(reqQ1.pop_front());
      req_valid[0] = reqQ0.size() > 0;
      if (reqQ0.size() > 0) {req_address[0], req_data_in[0], req_bytemask[0], req_write[0]} = reqQ0[0];
      req_valid[1] = reqQ1.size() > 0;
      if (reqQ1.size() > 0) {req_address[1], req_data_in[1], req_bytemask[1], req_write[1]} = reqQ1[0];
    end
  end

  task automatic applyStimulus(input int id, input logic [AW-1:0] addr, input logic [63:0] data,
                               input logic [7:0] mask, input logic wr);
    cmd_t c;
    c = {addr, data, mask, wr};
    if (id == 0) reqQ0.push_back(c);
    else reqQ1.push_back(c);
  endtask

  task automatic stepNeg();
    @(negedge clk);
    #2;
  endtask

  task automatic clearMon();
    firstHigh = -1;
    lastHigh  = -1;
    highCount = 0;
    doneCount = 0;
    for (int i = 0; i < NR; i++) doneData[i] = '0;
  endtask

  task automatic resetDut();
    stepNeg();
    reset = 1'b1;
    stepNeg();
    stepNeg();
    reset = 1'b0;
    clearMon();
    grantLog.delete();
  endtask

  task automatic waitDrain(input int maxCycles);
    int n;
    n = 0;
    while (!(reqQ0.size() == 0 && reqQ1.size() == 0 && req_valid == '0 && !mem_start_access)
           && n < maxCycles) begin
      stepNeg();
      n++;
    end
    if (n >= maxCycles) checkOutput("drainTimeout", 64'(n), 64'(maxCycles - 1));
    stepNeg();
  endtask

  task automatic checkLog(input string name, input int expLen, input int e0, input int e1,
                          input int e2, input int e3, input int e4, input int e5);
    int expv [6];
    expv = '{e0, e1, e2, e3, e4, e5};
    checkOutput({name, "Len"}, 64'(grantLog.size()), 64'(expLen));
    for (int i = 0; i < expLen && i < grantLog.size(); i++) checkOutput(name, 64'(grantLog[i]), 64'(expv[i]));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    clearMon();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    stepNeg();
    checkOutput("rstStart", mem_start_access, 1'b0);
    checkOutput("rstDone", req_done, 2'b00);
    checkOutput("rstAddress", mem_address, 20'h0);
    reset = 1'b0;
    clearMon();
    grantLog.delete();

    $display("[TB] scenario 1: lone read by requester 0");
    applyStimulus(0, 20'h00008, 64'h0, 8'h00, 1'b0);
    stepNeg();
    checkOutput("s1StartLow", mem_start_access, 1'b0);
    stepNeg();
    checkOutput("s1StartHigh", mem_start_access, 1'b1);
    checkOutput("s1Address", mem_address, 20'h00008);
    stepNeg();
    stepNeg();
    checkOutput("s1Done", req_done, 2'b01);
    checkOutput("s1Data", req_data_out, 64'h1111_0001_2222_0001);
    stepNeg();
    checkOutput("s1Idle", mem_start_access, 1'b0);
    checkOutput("s1NoDone", req_done, 2'b00);
    waitDrain(50);

    $display("[TB] scenario 2: simultaneous requests");
    resetDut();
    applyStimulus(0, 20'h00020, 64'h0, 8'h00, 1'b0);
    applyStimulus(1, 20'h00028, 64'h0, 8'h00, 1'b0);
    waitDrain(100);
    checkLog("s2Order", 2, 0, 1, 0, 0, 0, 0);
    checkOutput("s2StartSpan", 64'(lastHigh - firstHigh + 1), 64'd6);
    checkOutput("s2StartCount", 64'(highCount), 64'd6);
`ifdef DMEM_ARB_STATS_EN
    checkOutput("s6Grants0", stat_grants[0], 3'd1);
    checkOutput("s6Grants1", stat_grants[1], 3'd1);
    checkOutput("s6Wait1", stat_wait[1], 3'd4);
`endif

    $display("[TB] scenario 3: back-to-back reads against a waiting requester");
    resetDut();
    applyStimulus(0, 20'h00000, 64'h0, 8'h00, 1'b0);
    applyStimulus(0, 20'h00008, 64'h0, 8'h00, 1'b0);
    applyStimulus(0, 20'h00010, 64'h0, 8'h00, 1'b0);
    applyStimulus(0, 20'h00018, 64'h0, 8'h00, 1'b0);
    applyStimulus(1, 20'h00030, 64'h0, 8'h00, 1'b0);
    applyStimulus(1, 20'h00038, 64'h0, 8'h00, 1'b0);
    waitDrain(300);
    checkLog("s3Order", 6, 0, 1, 0, 1, 0, 0);
    checkOutput("s3DoneCount", 64'(doneCount), 64'd6);
`ifdef DMEM_ARB_STATS_EN
    checkOutput("s3Wait0Sat", stat_wait[0], 3'd7);
`endif

    $display("[TB] scenario 4: masked write then read back");
    resetDut();
    applyStimulus(1, 20'h00010, 64'hDEAD_BEEF_0000_0000, 8'hF0, 1'b1);
    stepNeg();
    stepNeg();
    applyStimulus(0, 20'h00010, 64'h0, 8'h00, 1'b0);
    waitDrain(100);
    checkLog("s4Order", 2, 1, 0, 0, 0, 0, 0);
    checkOutput("s4ReadBack", doneData[0], 64'hDEAD_BEEF_2222_0002);

    $display("[TB] scenario 5: reset during an access");
    resetDut();
    applyStimulus(0, 20'h00008, 64'h0, 8'h00, 1'b0);
    applyStimulus(1, 20'h00018, 64'h0, 8'h00, 1'b0);
    stepNeg();
    stepNeg();
    checkOutput("s5Busy", mem_start_access, 1'b1);
    reset = 1'b1;
    stepNeg();
    checkOutput("s5Abandon", mem_start_access, 1'b0);
    checkOutput("s5NoDone", req_done, 2'b00);
    reset = 1'b0;
    waitDrain(100);
    checkLog("s5Order", 3, 0, 0, 1, 0, 0, 0);
    checkOutput("s5DoneCount", 64'(doneCount), 64'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
